// File: rtl/dmem_pkg.sv
// Shared definitions for the LSU data memory.
//   - load funct3 encodings (LB/LH/LW/LBU/LHU) and store encodings (SB/SH/SW)
//   - error code constants reported on o_rsp_err
//   - helpers: byte-enable generation, store data replication, load extension,
//     alignment and illegal-funct3 checks
package dmem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_funct3_e;

    // Stores share encodings with the loads, so they cannot live in the same enum.
    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

    // Illegal encodings fall into the default arm and are checked as words.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'd0, 3'd4: be = 4'b0001 << off;
            3'd1, 3'd5: be = 4'b0011 << off;
            3'd2:       be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-aligned store data copied onto every lane so the byte enables pick the lane.
    function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] rep;
        case (size)
            2'b00:   rep = {4{wd[7:0]}};
            2'b01:   rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            LB:      r = {{24{b[7]}}, b};
            LH:      r = {{16{h[15]}}, h};
            LW:      r = word;
            LBU:     r = {24'h0, b};
            LHU:     r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port synchronous 32-bit RAM with per-byte write enables.
// Read-first: a write and a read of the same word in one cycle return the old data.
// No reset on the array so it maps onto block RAM.
//   i_clk    clock
//   i_en     access enable (read and/or write)
//   i_we     byte write enables, bit n writes bits [8n+7:8n]
//   i_addr   word index
//   i_wdata  write data
//   o_rdata  registered read data, valid the cycle after i_en
module dmem_bram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            rdata_q <= mem_q[i_addr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu_ram.sv
// RV32 load/store front end on a byte-addressed data RAM.
// Requests use valid/ready, responses come back in order with backpressure.
// Every accepted request (stores and faults included) produces exactly one response.
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid/o_req_ready   request handshake
//   i_req_write               1 = store, 0 = load
//   i_req_funct3              RV32 load/store funct3
//   i_req_addr                byte address
//   i_req_wdata               right-aligned store data
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_rdata               extended load data, 0 for stores and faults
//   o_rsp_err                 [0] misaligned / illegal funct3, [1] out of range
module dmem_lsu_ram
    import dmem_pkg::*;
#(
    parameter int MEM_DEPTH      = 4096,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int OUT_REG        = 0,
    parameter int RSP_DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err
);

    localparam int WORD_AW = MEM_ADDR_WIDTH - 2;
    localparam int PTR_W   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RSP_DEPTH + 1);

    // ---------------- request decode ----------------
    logic        acc;
    logic [1:0]  req_err;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    // Gated by reset so a request held valid during reset never touches the RAM.
    assign acc = i_req_valid && o_req_ready && i_rst_n;

    always_comb begin
        req_err = ERR_NONE;
        if (i_req_addr[31:MEM_ADDR_WIDTH] != '0) begin
            req_err = ERR_RANGE;
        end else if (is_misaligned(i_req_funct3, i_req_addr[1:0]) || is_illegal(i_req_funct3)) begin
            req_err = ERR_MISALIGN;
        end
    end

    assign ram_we    = (acc && i_req_write && (req_err == ERR_NONE))
                       ? be_gen(i_req_funct3, i_req_addr[1:0]) : 4'b0000;
    assign ram_wdata = wdata_rep(i_req_funct3[1:0], i_req_wdata);

    dmem_bram #(
        .WORDS (MEM_DEPTH / 4),
        .AW    (WORD_AW)
    ) u_bram (
        .i_clk   (i_clk),
        .i_en    (acc),
        .i_we    (ram_we),
        .i_addr  (i_req_addr[MEM_ADDR_WIDTH-1:2]),
        .i_wdata (ram_wdata),
        .o_rdata (ram_rdata)
    );

    // ---------------- stage 1: request meta alongside the RAM read ----------------
    logic        s1_valid_q;
    logic        s1_write_q;
    logic [2:0]  s1_funct3_q;
    logic [1:0]  s1_off_q;
    logic [1:0]  s1_err_q;

    logic        res1_valid;
    logic [31:0] res1_data;
    logic [1:0]  res1_err;

    always_comb begin
        res1_valid = s1_valid_q;
        res1_err   = s1_valid_q ? s1_err_q : ERR_NONE;
        res1_data  = '0;
        if (s1_valid_q && !s1_write_q && (s1_err_q == ERR_NONE)) begin
            res1_data = load_extend(s1_funct3_q, s1_off_q, ram_rdata);
        end
    end

    // ---------------- optional output register ----------------
    logic        fin_valid;
    logic [31:0] fin_data;
    logic [1:0]  fin_err;
    logic        s2_valid_d;

    if (OUT_REG != 0) begin : g_oreg
        logic        s2_valid_q;
        logic [31:0] s2_data_q;
        logic [1:0]  s2_err_q;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
                s2_err_q   <= ERR_NONE;
            end else begin
                s2_valid_q <= res1_valid;
                s2_data_q  <= res1_data;
                s2_err_q   <= res1_err;
            end
        end

        assign s2_valid_d = res1_valid;
        assign fin_valid  = s2_valid_q;
        assign fin_data   = s2_data_q;
        assign fin_err    = s2_err_q;
    end else begin : g_noreg
        assign s2_valid_d = 1'b0;
        assign fin_valid  = res1_valid;
        assign fin_data   = res1_data;
        assign fin_err    = res1_err;
    end

    // ---------------- response buffer ----------------
    logic [31:0]      buf_data_q [RSP_DEPTH];
    logic [1:0]       buf_err_q  [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ready_q, ready_d;
    logic             buf_empty;
    logic             bypass;
    logic             push;
    logic             buf_pop;
    logic [31:0]      occ_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign buf_empty = (count_q == '0);
    // With nothing queued and the consumer ready, the pipeline result is taken
    // straight off the output and never enters the buffer.
    assign bypass    = buf_empty && i_rsp_ready;
    assign push      = fin_valid && !bypass;
    assign buf_pop   = !buf_empty && i_rsp_ready;

    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(buf_pop);
        wr_ptr_d = push    ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = buf_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        // Every unretired request holds a credit: in the pipeline or in the buffer.
        occ_d    = 32'(acc) + 32'(s2_valid_d) + 32'(count_d);
        ready_d  = (occ_d < 32'(RSP_DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_write_q  <= 1'b0;
            s1_funct3_q <= '0;
            s1_off_q    <= '0;
            s1_err_q    <= ERR_NONE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
        end else begin
            s1_valid_q <= acc;
            if (acc) begin
                s1_write_q  <= i_req_write;
                s1_funct3_q <= i_req_funct3;
                s1_off_q    <= i_req_addr[1:0];
                s1_err_q    <= req_err;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    // Storage has no reset; the pointers and count decide what is live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= fin_data;
            buf_err_q[wr_ptr_q]  <= fin_err;
        end
    end

    assign o_req_ready = ready_q;
    assign o_rsp_valid = !buf_empty || fin_valid;
    assign o_rsp_rdata = buf_empty ? fin_data : buf_data_q[rd_ptr_q];
    assign o_rsp_err   = buf_empty ? fin_err  : buf_err_q[rd_ptr_q];

endmodule

// File: tb/tb_dmem_lsu_ram.sv
module tb_dmem_lsu_ram;

    localparam logic [2:0] F_B  = 3'd0;
    localparam logic [2:0] F_H  = 3'd1;
    localparam logic [2:0] F_W  = 3'd2;
    localparam logic [2:0] F_BU = 3'd4;
    localparam logic [2:0] F_HU = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    logic        v2, rdy2, w2, rv2, rr2;
    logic [2:0]  f3_2;
    logic [31:0] a2, d2, rd2;
    logic [1:0]  re2;

    dmem_lsu_ram #(.MEM_DEPTH(4096), .MEM_ADDR_WIDTH(12), .OUT_REG(0), .RSP_DEPTH(2)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_write(req_write),
        .i_req_funct3(req_f3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err)
    );

    dmem_lsu_ram #(.MEM_DEPTH(4096), .MEM_ADDR_WIDTH(12), .OUT_REG(1), .RSP_DEPTH(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(v2), .o_req_ready(rdy2), .i_req_write(w2),
        .i_req_funct3(f3_2), .i_req_addr(a2), .i_req_wdata(d2),
        .o_rsp_valid(rv2), .i_rsp_ready(rr2),
        .o_rsp_rdata(rd2), .o_rsp_err(re2)
    );

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        logic [1:0]  exp_e;
    } vec_t;

    vec_t        vecs[$];
    logic [33:0] rq[$];
    int          total = 0;
    int          bad   = 0;

    // Collect every handshaken response of the main instance in order.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) rq.push_back({rsp_err, rsp_rdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] ee);
        vec_t v;
        v.w = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_d = ed; v.exp_e = ee;
        vecs.push_back(v);
    endtask

    // Hold the request until accepted, then drop valid just after the accepting edge.
    task automatic send(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int t;
        t = 0;
        req_valid = 1'b1; req_write = w; req_f3 = f3; req_addr = a; req_wdata = d;
        while (!req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: addr %h not accepted, got ready=0 want ready=1", a);
            req_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input string nm, output logic [31:0] d, output logic [1:0] e);
        int t;
        t = 0;
        while (rq.size() == 0 && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        if (rq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_timeout: got no response want one", nm);
            d = '0; e = '0;
        end else begin
            {e, d} = rq.pop_front();
        end
    endtask

    task automatic txn(input string nm, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] ed, input logic [1:0] ee);
        logic [31:0] d;
        logic [1:0]  e;
        send(w, f3, a, wd);
        wait_rsp(nm, d, e);
        chk({nm, "_data"}, d, ed);
        chk({nm, "_err"}, 32'(e), 32'(ee));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  e;
        int          late;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_f3 = '0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        v2 = 1'b0; w2 = 1'b0; f3_2 = '0; a2 = '0; d2 = '0; rr2 = 1'b1;

        // vector table: write, funct3, addr, wdata, expected rdata, expected err
        add_vec(1, F_W,  32'h0000_0000, 32'h1122_3344, 32'h0000_0000, 2'b00);
        add_vec(1, F_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 2'b00);
        add_vec(0, F_B,  32'h0000_0100, 32'h0,         32'hFFFF_FFEF, 2'b00);
        add_vec(0, F_BU, 32'h0000_0100, 32'h0,         32'h0000_00EF, 2'b00);
        add_vec(0, F_H,  32'h0000_0100, 32'h0,         32'hFFFF_BEEF, 2'b00);
        add_vec(0, F_HU, 32'h0000_0100, 32'h0,         32'h0000_BEEF, 2'b00);
        add_vec(0, F_W,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 2'b00);
        add_vec(0, F_B,  32'h0000_0103, 32'h0,         32'hFFFF_FFDE, 2'b00);
        add_vec(0, F_BU, 32'h0000_0102, 32'h0,         32'h0000_00AD, 2'b00);
        add_vec(0, F_H,  32'h0000_0102, 32'h0,         32'hFFFF_DEAD, 2'b00);
        add_vec(0, F_HU, 32'h0000_0102, 32'h0,         32'h0000_DEAD, 2'b00);
        add_vec(1, F_B,  32'h0000_0102, 32'hAAAA_AA55, 32'h0000_0000, 2'b00);
        add_vec(0, F_W,  32'h0000_0100, 32'h0,         32'hDE55_BEEF, 2'b00);
        add_vec(0, F_H,  32'h0000_0101, 32'h0,         32'h0000_0000, 2'b01);
        add_vec(0, F_W,  32'h0000_0102, 32'h0,         32'h0000_0000, 2'b01);
        add_vec(1, F_W,  32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 2'b10);
        add_vec(0, F_W,  32'h0000_0000, 32'h0,         32'h1122_3344, 2'b00);
        add_vec(0, F_H,  32'h0000_1001, 32'h0,         32'h0000_0000, 2'b10);
        add_vec(0, F_W,  32'h0000_1000, 32'h0,         32'h0000_0000, 2'b10);
        add_vec(0, 3'd3, 32'h0000_0100, 32'h0,         32'h0000_0000, 2'b01);
        add_vec(1, 3'd6, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01);
        add_vec(1, F_W,  32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 2'b01);
        add_vec(0, F_W,  32'h0000_0100, 32'h0,         32'hDE55_BEEF, 2'b00);
        add_vec(1, F_W,  32'h0000_0104, 32'hFFFF_FFFF, 32'h0000_0000, 2'b00);
        add_vec(1, F_H,  32'h0000_0106, 32'h1234_CAFE, 32'h0000_0000, 2'b00);
        add_vec(0, F_W,  32'h0000_0104, 32'h0,         32'hCAFE_FFFF, 2'b00);
        add_vec(1, F_B,  32'h0000_0105, 32'h0000_0077, 32'h0000_0000, 2'b00);
        add_vec(0, F_W,  32'h0000_0104, 32'h0,         32'hCAFE_77FF, 2'b00);
        add_vec(1, F_W,  32'h0000_0FFC, 32'hCAFE_BABE, 32'h0000_0000, 2'b00);
        add_vec(0, F_W,  32'h0000_0FFC, 32'h0,         32'hCAFE_BABE, 2'b00);
        add_vec(0, F_W,  32'h8000_0100, 32'h0,         32'h0000_0000, 2'b10);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].f3, vecs[i].addr,
                vecs[i].wdata, vecs[i].exp_d, vecs[i].exp_e);
        end

        // Response appears in the cycle right after the accept.
        send(0, F_W, 32'h100, 32'h0);
        @(negedge clk);
        chk("lat0_valid", 32'(rsp_valid), 32'd1);
        wait_rsp("lat0", d, e);
        chk("lat0_data", d, 32'hDE55_BEEF);

        // Store then load of the same word in consecutive cycles.
        send(1, F_W, 32'h200, 32'hA1B2_C3D4);
        send(0, F_W, 32'h200, 32'h0);
        wait_rsp("b2b_sw", d, e);
        chk("b2b_sw_data", d, 32'h0);
        wait_rsp("b2b_lw", d, e);
        chk("b2b_lw_data", d, 32'hA1B2_C3D4);

        // Backpressure: two credits, then stall; release and drain in order.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(0, F_W, 32'h100, 32'h0);
        send(0, F_W, 32'h104, 32'h0);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        fork
            begin
                send(0, F_W, 32'h000, 32'h0);
                send(0, F_W, 32'hFFC, 32'h0);
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
                    chk("bp_hold_data", rsp_rdata, 32'hDE55_BEEF);
                    chk("bp_hold_err", 32'(rsp_err), 32'd0);
                    chk("bp_hold_ready", 32'(req_ready), 32'd0);
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        join
        wait_rsp("bp0", d, e); chk("bp0_data", d, 32'hDE55_BEEF);
        wait_rsp("bp1", d, e); chk("bp1_data", d, 32'hCAFE_77FF);
        wait_rsp("bp2", d, e); chk("bp2_data", d, 32'h1122_3344);
        wait_rsp("bp3", d, e); chk("bp3_data", d, 32'hCAFE_BABE);
        chk("bp_extra", 32'(rq.size()), 32'd0);

        // Reset with two responses pending.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(0, F_W, 32'h100, 32'h0);
        send(0, F_W, 32'h104, 32'h0);
        chk("mr_pending", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("mr_ready", 32'(req_ready), 32'd1);
        late = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid) late++;
        end
        chk("mr_no_late_valid", 32'(late), 32'd0);
        chk("mr_no_late_rsp", 32'(rq.size()), 32'd0);
        @(posedge clk); #1;
        txn("mr_mem", 0, F_W, 32'h100, 32'h0, 32'hDE55_BEEF, 2'b00);

        // OUT_REG=1 instance: load accepted at edge E must show valid only after E+1.
        @(posedge clk); #1;
        v2 = 1'b1; w2 = 1'b1; f3_2 = F_W; a2 = 32'h40; d2 = 32'h0BAD_F00D;
        @(posedge clk); #1;
        v2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("oreg_ready", 32'(rdy2), 32'd1);
        v2 = 1'b1; w2 = 1'b0; f3_2 = F_W; a2 = 32'h40; d2 = 32'h0;
        @(posedge clk); #1;
        v2 = 1'b0;
        @(negedge clk);
        chk("oreg_n1_valid", 32'(rv2), 32'd0);
        @(negedge clk);
        chk("oreg_n2_valid", 32'(rv2), 32'd1);
        chk("oreg_n2_data", rd2, 32'h0BAD_F00D);
        chk("oreg_n2_err", 32'(re2), 32'd0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
